// File: rtl/fifo_storage_array.sv
// Purpose: depth x width register file, one write port, one combinational read port.
// Latency: write lands on the clock edge; read data follows raddr with no register.
// Backpressure: none; the owner decides when to write and which entry to read.
module fifo_storage_array #(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(depth)-1:0] waddr,
    input  logic [width-1:0]         wdata,
    input  logic [$clog2(depth)-1:0] raddr,
    output logic [width-1:0]         rdata
);

    logic [width-1:0] mem [depth];

    // Clear every entry on reset so the read port is never X; otherwise write one entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < depth; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_valid_ready_fifo.sv
// Purpose: first-word-fall-through FIFO between a valid/ready producer and consumer.
// Latency: a word pushed at edge k is on out_data with out_valid high from edge k on.
// Backpressure: in_ready drops only when full; it never looks at out_ready.
module sync_valid_ready_fifo #(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [width-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [width-1:0]           out_data,
    output logic [$clog2(depth):0]     count
);

    localparam int ptr_w = $clog2(depth);
    localparam int cnt_w = ptr_w + 1;

    // Pointer wrap relies on depth being a power of two.
    if (depth < 2 || (depth & (depth - 1)) != 0) begin : g_bad_depth
        $error("sync_valid_ready_fifo: depth must be a power of two and at least 2");
    end
    if (width < 1) begin : g_bad_width
        $error("sync_valid_ready_fifo: width must be at least 1");
    end

    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;
    logic [cnt_w-1:0] cnt_q;
    logic             push;
    logic             pop;

    // Full/empty come from the counter alone; pointer equality is ambiguous.
    assign in_ready  = (cnt_q != cnt_w'(depth));
    assign out_valid = (cnt_q != '0);
    assign count     = cnt_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Advance pointers on their own handshakes and track occupancy; reset wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ptr_w'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_w'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + cnt_w'(1);
                2'b01:   cnt_q <= cnt_q - cnt_w'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    fifo_storage_array #(
        .width (width),
        .depth (depth)
    ) u_storage (
        .clk   (clk),
        .reset (reset),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (out_data)
    );

endmodule

// File: tb/tb_sync_valid_ready_fifo.sv
// Purpose: scoreboard bench for sync_valid_ready_fifo at width 8, depth 4.
// Latency: one call of drive_cycle is one clock edge; checks sit 1 time unit off the edge.
// Backpressure: the bench model decides accept/pop from its own occupancy, not the DUT's.
module tb_sync_valid_ready_fifo;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [2:0]   count;

    logic [W-1:0] sb_q[$];
    int           n_checks;
    int           n_errors;

    sync_valid_ready_fifo #(.width(W), .depth(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle, predict the handshakes from the model, then check state after the edge.
    task automatic drive_cycle(input logic iv, input logic [W-1:0] d, input logic ordy, input logic rst);
        bit m_push;
        bit m_pop;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        reset     = rst;
        m_push    = 1'b0;
        m_pop     = 1'b0;
        #1;
        if (!rst) begin
            chk("pre_in_ready", in_ready, sb_q.size() != D);
            chk("pre_out_valid", out_valid, sb_q.size() != 0);
            m_push = iv && (sb_q.size() < D);
            m_pop  = ordy && (sb_q.size() > 0);
            if (m_pop) chk("pop_data", out_data, sb_q[0]);
        end
        @(posedge clk);
        if (rst) begin
            sb_q.delete();
        end else begin
            if (m_pop) void'(sb_q.pop_front());
            if (m_push) sb_q.push_back(d);
        end
        #1;
        chk("count", count, sb_q.size());
        chk("in_ready", in_ready, sb_q.size() != D);
        chk("out_valid", out_valid, sb_q.size() != 0);
        if (sb_q.size() != 0) chk("head_data", out_data, sb_q[0]);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        reset     = 1'b1;

        // Reset for two edges while a word is being offered.
        drive_cycle(1'b1, 8'hFF, 1'b0, 1'b1);
        drive_cycle(1'b1, 8'hFF, 1'b0, 1'b1);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_count", count, 3'd0);

        // Idle cycle: offered FF must not have been stored by the reset.
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("idle_out_data", out_data, 8'h00);

        // Fill to full with the consumer stalled.
        drive_cycle(1'b1, 8'h11, 1'b0, 1'b0);
        chk("fill_cnt1", count, 3'd1);
        drive_cycle(1'b1, 8'h22, 1'b0, 1'b0);
        drive_cycle(1'b1, 8'h33, 1'b0, 1'b0);
        drive_cycle(1'b1, 8'h44, 1'b0, 1'b0);
        chk("full_cnt", count, 3'd4);
        chk("full_in_ready", in_ready, 1'b0);

        // Fifth offer is held off.
        drive_cycle(1'b1, 8'h55, 1'b0, 1'b0);
        chk("held_cnt", count, 3'd4);

        // Pop at full with 55 still offered: only the pop happens.
        drive_cycle(1'b1, 8'h55, 1'b1, 1'b0);
        chk("full_pop_cnt", count, 3'd3);
        drive_cycle(1'b1, 8'h55, 1'b1, 1'b0);
        drive_cycle(1'b1, 8'h66, 1'b1, 1'b0);
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("wrap_cnt", count, 3'd2);
        chk("wrap_head", out_data, 8'h55);
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drained_cnt", count, 3'd0);

        // Push into empty with out_ready high: no pop that cycle.
        drive_cycle(1'b1, 8'hA5, 1'b1, 1'b0);
        chk("empty_push_valid", out_valid, 1'b1);
        chk("empty_push_data", out_data, 8'hA5);
        drive_cycle(1'b1, 8'hB6, 1'b0, 1'b0);

        // Simultaneous push and pop at count 2.
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
            chk("simul_cnt", count, 3'd2);
        end

        // Build count 3, then reset in the same cycle as a push and a pop.
        drive_cycle(1'b1, 8'hC3, 1'b0, 1'b0);
        chk("pre_rst_cnt", count, 3'd3);
        drive_cycle(1'b1, 8'hCC, 1'b1, 1'b1);
        chk("midrst_cnt", count, 3'd0);
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_data", out_data, 8'h00);
        drive_cycle(1'b1, 8'h7E, 1'b0, 1'b0);
        chk("post_rst_head", out_data, 8'h7E);
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 300; i++) begin
            drive_cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                        1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
